// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared widths, limits and parameter checks for handshake stages
// Contents:
//   HS_MAX_SLOTS    largest legal FIFO depth
//   hs_clog2_min1   clog2 clamped to at least 1 bit (pointer widths)
//   hs_slots_legal  true when a depth lies in 1..HS_MAX_SLOTS
package handshake_pkg;

    localparam int HS_MAX_SLOTS = 256;

    function automatic int hs_clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit hs_slots_legal(input int n);
        return (n >= 1) && (n <= HS_MAX_SLOTS);
    endfunction

endpackage

// File: rtl/handshake_fifo_ctrl.sv
// rtl/handshake_fifo_ctrl.sv - pointer, occupancy and full/empty tracking for handshake_fifo_buffer
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low
//   push    store a token at wr_ptr this cycle
//   pop     retire the token at rd_ptr this cycle
//   wr_ptr  slot the next stored token goes to
//   rd_ptr  slot holding the head token
//   full    count == NUM_SLOTS
//   empty   count == 0
module handshake_fifo_ctrl
    import handshake_pkg::*;
#(
    parameter int NUM_SLOTS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic                                pop,
    output logic [hs_clog2_min1(NUM_SLOTS)-1:0] wr_ptr,
    output logic [hs_clog2_min1(NUM_SLOTS)-1:0] rd_ptr,
    output logic                                full,
    output logic                                empty
);

    localparam int PW = hs_clog2_min1(NUM_SLOTS);
    localparam int CW = $clog2(NUM_SLOTS + 1);

    logic [CW-1:0] count;

    // Explicit wrap so non-power-of-two depths never walk past the last slot.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign full  = (count == CW'(NUM_SLOTS));
    assign empty = (count == '0);

endmodule

// File: rtl/handshake_fifo_buffer.sv
// rtl/handshake_fifo_buffer.sv - elastic valid/ready FIFO breaking the handshake path
// Optional feature macro: HANDSHAKE_FIFO_BYPASS_EN (empty buffer becomes transparent).
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   ins         input token payload
//   ins_valid   producer has a token
//   ins_ready   buffer accepts a token this cycle (registered state only)
//   outs        head-of-queue payload
//   outs_valid  buffer presents a token
//   outs_ready  consumer accepts the token
module handshake_fifo_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PW = hs_clog2_min1(NUM_SLOTS);

    generate
        if (!hs_slots_legal(NUM_SLOTS)) begin : g_bad_slots
            $error("handshake_fifo_buffer: NUM_SLOTS must lie in 1..%0d", HS_MAX_SLOTS);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  alive;
    logic                  bypass_active;
    logic                  push;
    logic                  pop;
    logic                  store;
    logic                  retire;

    // Low throughout reset, high from the first edge after release; keeps
    // ins_ready and the bypass path quiet during reset without a
    // combinational path from the reset pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alive <= 1'b0;
        else      alive <= 1'b1;
    end

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    assign bypass_active = alive & empty;
`else
    assign bypass_active = 1'b0;
`endif

    assign ins_ready  = alive & ~full;
    assign outs_valid = bypass_active ? ins_valid : (alive & ~empty);
    assign outs       = bypass_active ? ins : mem[rd_ptr];

    assign push   = ins_valid & ins_ready;
    assign pop    = outs_valid & outs_ready;
    // A token handed straight through while empty is never stored, and the
    // pop it causes must not move rd_ptr.
    assign store  = push & ~(bypass_active & outs_ready);
    assign retire = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
        end else if (store) begin
            mem[wr_ptr] <= ins;
        end
    end

    handshake_fifo_ctrl #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (store),
        .pop    (retire),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// tb/tb_handshake_fifo_buffer.sv - randomized self-checking bench with queue reference model
module tb_handshake_fifo_buffer;

    localparam int DW = 27;
    localparam int NS = 3;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    bit            alive;

    handshake_fifo_buffer #(
        .DATA_WIDTH (DW),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare just after, then
    // advance the model at the rising edge. accepted reports whether the
    // producer's token was taken.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output bit accepted);
        bit            exp_rdy;
        bit            exp_vld;
        bit            through;
        logic [DW-1:0] exp_out;
        @(negedge clk);
        ins_valid  = v;
        ins        = d;
        outs_ready = r;
        #1;
        exp_rdy = alive && (q.size() < NS);
        through = BYPASS && alive && (q.size() == 0);
        exp_vld = through ? v : (alive && q.size() != 0);
        exp_out = through ? d : ((q.size() != 0) ? q[0] : '0);
        check("ins_ready", {31'b0, ins_ready}, {31'b0, exp_rdy});
        check("outs_valid", {31'b0, outs_valid}, {31'b0, exp_vld});
        if (exp_vld) check("outs", {5'b0, outs}, {5'b0, exp_out});
        @(posedge clk);
        accepted = v && exp_rdy;
        if (!(through && v && r)) begin
            if (exp_vld && r) void'(q.pop_front());
            if (accepted) q.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        ins_valid  = 1'b1;
        ins        = DW'($urandom);
        outs_ready = 1'b1;
        #1;
        q.delete();
        alive = 1'b0;
        check("rst_ins_ready", {31'b0, ins_ready}, 32'd0);
        check("rst_outs_valid", {31'b0, outs_valid}, 32'd0);
        check("rst_outs", {5'b0, outs}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ins_ready", {31'b0, ins_ready}, 32'd0);
        check("rst_hold_outs_valid", {31'b0, outs_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        alive = 1'b1;
    endtask

    initial begin
        bit            acc;
        bit            hold;
        logic [DW-1:0] pend;
        int            rdy_pct;

        rst        = 1'b0;
        ins_valid  = 1'b1;
        ins        = '1;
        outs_ready = 1'b0;
        alive      = 1'b0;
        do_reset();

        // single token, visible after the accepting edge
        step(1'b1, 27'h75F79E7, 1'b0, acc);
        check("single_accepted", {31'b0, acc}, 32'd1);
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);

        // fill past capacity, then full+pop with producer still offering
        step(1'b1, 27'd1, 1'b0, acc);
        step(1'b1, 27'd2, 1'b0, acc);
        step(1'b1, 27'd3, 1'b0, acc);
        step(1'b1, 27'd4, 1'b0, acc);
        check("overflow_held", {31'b0, acc}, 32'd0);
        step(1'b1, 27'd4, 1'b1, acc);
        check("full_pop_no_push", {31'b0, acc}, 32'd0);
        check("full_pop_depth", q.size(), NS - 1);
        step(1'b1, 27'd4, 1'b0, acc);
        check("refill_after_pop", {31'b0, acc}, 32'd1);
        repeat (4) step(1'b0, '0, 1'b1, acc);
        check("drained", q.size(), 0);

        // streaming across pointer wraps
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(i), 1'b1, acc);
            check("stream_accept", {31'b0, acc}, 32'd1);
        end
        repeat (3) step(1'b0, '0, 1'b1, acc);

        // transparent pass-through check (model expects it only in bypass build)
        step(1'b1, 27'h15, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);

        // randomized traffic with a reset in the middle
        hold = 1'b0;
        pend = '0;
        for (int i = 0; i < 600; i++) begin
            bit v;
            if (i == 300) begin
                do_reset();
                hold = 1'b0;
            end
            rdy_pct = ((i / 50) % 3 == 0) ? 20 : (((i / 50) % 3 == 1) ? 80 : 50);
            if (hold) begin
                v = 1'b1;
            end else begin
                v    = ($urandom_range(0, 99) < 60);
                pend = DW'($urandom);
            end
            step(v, pend, ($urandom_range(0, 99) < rdy_pct), acc);
            hold = v && !acc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
